// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage hazard/sequencing controller.
package pipe_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned MD_CNT_W = 8;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StRun  = ST_RUN,
        StBusy = ST_BUSY,
        StDone = ST_DONE
    } md_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != '1)) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage stall controller: load-use detection, mul/div sequencing and a
// saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_md,
    input  logic             id_div,
    input  logic             id_hilo_rd,
    input  logic [REG_W-1:0] ern,
    input  logic             ewreg,
    input  logic             em2reg,
    output logic             wpcir,
    output logic             id_kill,
    output logic             md_start,
    output logic             md_busy,
    output logic             hilo_we,
    output logic [CNT_W-1:0] stall_cnt
);

    if (MUL_LAT < 2 || MUL_LAT > 255 || DIV_LAT < 2 || DIV_LAT > 255) begin : g_bad_lat
        $error("pipe_hazard_ctrl: MUL_LAT/DIV_LAT must lie in 2..255");
    end

    localparam logic [MD_CNT_W-1:0] MulLoad = MD_CNT_W'(MUL_LAT - 2);
    localparam logic [MD_CNT_W-1:0] DivLoad = MD_CNT_W'(DIV_LAT - 2);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                md_busy_q, md_busy_d;
    logic                hilo_we_q, hilo_we_d;
    logic [MD_CNT_W-1:0] load;
    logic                lu, md_hz, stall;

    always_comb begin
        lu = ewreg & em2reg & (ern != '0) &
             ((id_use_rs & (ern == id_rs)) | (id_use_rt & (ern == id_rt)));
        md_hz    = (state_q != StRun) & (id_md | id_hilo_rd);
        stall    = lu | md_hz;
        wpcir    = ~stall;
        id_kill  = stall;
        md_start = (state_q == StRun) & id_md & ~lu;
        load     = id_div ? DivLoad : MulLoad;

        // cnt holds the BUSY cycles still to run, so DONE (hilo_we) lands at T+LAT-1.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (md_start) begin
                    cnt_d   = load;
                    state_d = (load == '0) ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (cnt_q <= MD_CNT_W'(1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            StDone:  state_d = StRun;
            default: state_d = StRun;
        endcase

        md_busy_d = (state_d != StRun);
        hilo_we_d = (state_d == StDone);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
            hilo_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
            hilo_we_q <= hilo_we_d;
        end
    end

    assign md_busy = md_busy_q;
    assign hilo_we = hilo_we_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock  (clock),
        .resetn (resetn),
        .inc    (stall),
        .value  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random bench for pipe_hazard_ctrl against a cycle-timeline model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 32;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [4:0]       id_rs, id_rt, ern;
    logic             id_use_rs, id_use_rt, id_md, id_div, id_hilo_rd, ewreg, em2reg;
    logic             wpcir, id_kill, md_start, md_busy, hilo_we;
    logic [CNT_W-1:0] stall_cnt;

    pipe_hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .id_md      (id_md),
        .id_div     (id_div),
        .id_hilo_rd (id_hilo_rd),
        .ern        (ern),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .wpcir      (wpcir),
        .id_kill    (id_kill),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .hilo_we    (hilo_we),
        .stall_cnt  (stall_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: the unit is free from cycle m_free_at on; HI/LO written at m_we_at.
    int m_cyc = 0;
    int m_free_at = 0;
    int m_we_at = -1;
    int m_stalls = 0;
    bit e_stall;
    logic o_wpcir, o_start;
    int we_cycles[$];
    int st_cycles[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        id_rs = '0; id_rt = '0; ern = '0;
        id_use_rs = 0; id_use_rt = 0; id_md = 0; id_div = 0; id_hilo_rd = 0;
        ewreg = 0; em2reg = 0;
    endtask

    task automatic model_reset();
        m_free_at = m_cyc;
        m_we_at   = -1;
        m_stalls  = 0;
    endtask

    task automatic cycle_check();
        bit lu, idle, stall, start;
        int lat;
        @(negedge clock);
        lu = ewreg && em2reg && (ern != 0) &&
             ((id_use_rs && ern == id_rs) || (id_use_rt && ern == id_rt));
        idle  = (m_cyc >= m_free_at);
        stall = lu || (!idle && (id_md || id_hilo_rd));
        start = idle && id_md && !lu;
        chk("wpcir", wpcir, !stall);
        chk("id_kill", id_kill, stall);
        chk("md_start", md_start, start);
        chk("md_busy", md_busy, !idle);
        chk("hilo_we", hilo_we, m_cyc == m_we_at);
        chk("stall_cnt", stall_cnt, (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls);
        o_wpcir = wpcir;
        o_start = md_start;
        if (hilo_we === 1'b1) we_cycles.push_back(m_cyc);
        if (md_start === 1'b1) st_cycles.push_back(m_cyc);
        e_stall = stall;
        if (start) begin
            lat       = id_div ? DIV_LAT : MUL_LAT;
            m_free_at = m_cyc + lat;
            m_we_at   = m_cyc + lat - 1;
        end
        if (stall) m_stalls++;
        m_cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int t, n;
        idle_in();
        resetn = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wpcir", wpcir, 1);
        chk("rst_id_kill", id_kill, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_hilo_we", hilo_we, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        resetn = 1;
        model_reset();

        // Load-use on rs, then the same with ern=0.
        ewreg = 1; em2reg = 1; ern = 5; id_rs = 5; id_use_rs = 1;
        cycle_check();
        chk("t1_lu_wpcir", o_wpcir, 0);
        idle_in();
        cycle_check();
        chk("t1_cnt", stall_cnt, 1);
        ewreg = 1; em2reg = 1; ern = 0; id_rs = 0; id_use_rs = 1;
        cycle_check();
        chk("t1_r0_wpcir", o_wpcir, 1);
        idle_in();
        cycle_check();

        // Single mult.
        we_cycles.delete();
        t = m_cyc;
        id_md = 1;
        cycle_check();
        idle_in();
        repeat (6) cycle_check();
        chk("t2_we_count", we_cycles.size(), 1);
        if (we_cycles.size() == 1) chk("t2_we_at", we_cycles[0] - t, MUL_LAT - 1);

        // div then mflo held in ID until it issues.
        t = m_cyc;
        id_md = 1; id_div = 1;
        cycle_check();
        idle_in();
        id_hilo_rd = 1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle_check();
            if (!e_stall) break;
            n++;
        end
        chk("t3_mflo_stalls", n, DIV_LAT - 1);
        chk("t3_issue_at", m_cyc - 1 - t, DIV_LAT);
        chk("t3_stall_cnt", stall_cnt, 1 + DIV_LAT - 1);
        idle_in();
        cycle_check();

        // div then an independent add flows during BUSY.
        id_md = 1; id_div = 1;
        cycle_check();
        idle_in();
        id_use_rs = 1; id_rs = 3; ern = 4; ewreg = 1; em2reg = 1;
        cycle_check();
        chk("t3_add_flows", o_wpcir, 1);
        idle_in();
        repeat (DIV_LAT + 2) cycle_check();

        // Back-to-back mult, second held until the unit is free.
        we_cycles.delete();
        st_cycles.delete();
        id_md = 1;
        cycle_check();
        for (int i = 0; i < 10; i++) begin
            cycle_check();
            if (!e_stall) break;
        end
        idle_in();
        repeat (10) cycle_check();
        chk("t4_starts", st_cycles.size(), 2);
        chk("t4_we_count", we_cycles.size(), 2);
        if (st_cycles.size() == 2) chk("t4_start_gap", st_cycles[1] - st_cycles[0], MUL_LAT);
        if (we_cycles.size() == 2) chk("t4_we_gap", we_cycles[1] - we_cycles[0], MUL_LAT);

        // mult blocked by load-use on rt.
        ewreg = 1; em2reg = 1; ern = 7; id_rt = 7; id_use_rt = 1; id_md = 1;
        cycle_check();
        chk("t5_blocked", o_start, 0);
        ewreg = 0;
        cycle_check();
        chk("t5_started", o_start, 1);
        idle_in();
        repeat (6) cycle_check();

        // Reset in the middle of a div.
        id_md = 1; id_div = 1;
        cycle_check();
        idle_in();
        repeat (2) cycle_check();
        resetn = 0;
        #1;
        chk("t6_busy_now", md_busy, 0);
        chk("t6_we_now", hilo_we, 0);
        chk("t6_cnt_now", stall_cnt, 0);
        @(posedge clock);
        #1;
        resetn = 1;
        model_reset();
        we_cycles.delete();
        repeat (DIV_LAT + 8) cycle_check();
        chk("t6_no_we", we_cycles.size(), 0);

        // Saturation: long load-use stall.
        ewreg = 1; em2reg = 1; ern = 9; id_rs = 9; id_use_rs = 1;
        repeat (CNT_MAX + 40) cycle_check();
        chk("sat_value", stall_cnt, CNT_MAX);
        idle_in();
        cycle_check();

        // Random traffic from a fresh reset.
        resetn = 0;
        #1;
        @(posedge clock);
        #1;
        resetn = 1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ern        = 5'($urandom_range(0, 3));
            id_use_rs  = 1'($urandom_range(0, 1));
            id_use_rt  = 1'($urandom_range(0, 1));
            ewreg      = 1'($urandom_range(0, 1));
            em2reg     = ($urandom_range(0, 2) == 0);
            id_md      = ($urandom_range(0, 5) == 0);
            id_div     = ($urandom_range(0, 3) == 0);
            id_hilo_rd = ($urandom_range(0, 3) == 0);
            cycle_check();
        end
        idle_in();
        repeat (DIV_LAT + 2) cycle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
